display_scan_controller: RTL and testbench

- Parametrised multiplexed 7-segment scanner. Successor to the fixed 8-digit anode rotator.
- Divides clk into per-digit time slots and drives one active-low anode per slot.
- Exports the digit index as `seg_sel` for the downstream segment mux.
- Adds versus the fixed rotator: runtime digit-enable mask with skipping of disabled digits, anti-ghosting blank time at each slot start, and a frame-start pulse.

---
 rtl/display_pkg.sv | 58 +++++
 rtl/scan_prescaler.sv | 57 +++++
 rtl/display_scan_controller.sv | 98 +++++++++
 tb/tb_display_scan_controller.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/display_pkg.sv
// Shared types and helpers for the multiplexed 7-segment scanner.
//
// Contents:
//   MAX_DIGITS        largest digit count any scanner build supports (16)
//   IDX_W             width of a digit index at MAX_DIGITS
//   scan_state_t      per-slot phase: SCAN_BLANK (anodes off) / SCAN_DRIVE
//   next_idx_t        result of the circular enabled-digit search
//   anode_all_off(n)  active-low anode vector with the low n bits high
//   next_enabled_idx  circular search for the next enabled digit after cur
package display_pkg;

  localparam int MAX_DIGITS = 16;
  localparam int IDX_W      = 4;

  typedef enum logic {
    SCAN_BLANK = 1'b0,
    SCAN_DRIVE = 1'b1
  } scan_state_t;

  typedef struct packed {
    logic             found;  // at least one digit enabled
    logic             wrap;   // search passed index n-1 (new idx <= cur)
    logic [IDX_W-1:0] idx;
  } next_idx_t;

  function automatic logic [MAX_DIGITS-1:0] anode_all_off(input int n);
    logic [MAX_DIGITS-1:0] r;
    r = '0;
    for (int i = 0; i < MAX_DIGITS; i++) begin
      if (i < n) r[i] = 1'b1;
    end
    return r;
  endfunction

  // Candidates are cur+1, cur+2, ... modulo n; the first enabled one wins.
  // With a single enabled digit the search comes all the way round to cur,
  // which counts as a wrap.
  function automatic next_idx_t next_enabled_idx(
    input logic [MAX_DIGITS-1:0] mask,
    input logic [IDX_W-1:0]      cur,
    input int                    n
  );
    next_idx_t      r;
    logic [IDX_W:0] c;
    r = '0;
    for (int i = 1; i <= MAX_DIGITS; i++) begin
      c = {1'b0, cur} + (IDX_W+1)'(i);
      if (c >= (IDX_W+1)'(n)) c = c - (IDX_W+1)'(n);
      if (i <= n && !r.found && mask[c[IDX_W-1:0]]) begin
        r.found = 1'b1;
        r.idx   = c[IDX_W-1:0];
        r.wrap  = (c[IDX_W-1:0] <= cur);
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/scan_prescaler.sv
// Slot timer for the display scanner.
//
// Counts slot_cnt through 0..TICK_DIV-1 and tracks the per-slot phase as a
// two-state FSM (SCAN_BLANK while slot_cnt < BLANK_CYCLES, else SCAN_DRIVE).
//
// Ports:
//   clk           system clock
//   reset         synchronous active-high reset
//   slot_end      high on the last cycle of each slot (slot_cnt == TICK_DIV-1)
//   blank_active  registered FSM state: 1 = SCAN_BLANK, 0 = SCAN_DRIVE
module scan_prescaler
  import display_pkg::*;
#(
  parameter int TICK_DIV     = 100000,
  parameter int BLANK_CYCLES = 16
) (
  input  logic clk,
  input  logic reset,
  output logic slot_end,
  output logic blank_active
);

  localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TICK_DIV - 1);
  localparam logic [CNT_W-1:0] BLANK_N  = CNT_W'(BLANK_CYCLES);
  localparam scan_state_t RESET_STATE = (BLANK_CYCLES > 0) ? SCAN_BLANK : SCAN_DRIVE;

  logic [CNT_W-1:0] slot_cnt;
  logic [CNT_W-1:0] cnt_next;
  scan_state_t      state;
  scan_state_t      state_next;

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      slot_cnt <= '0;
      state    <= RESET_STATE;
    end else begin
      slot_cnt <= cnt_next;
      state    <= state_next;
    end
  end

  // Next state: the phase is registered alongside the counter so it always
  // describes the slot_cnt value held in the same cycle.
  always_comb begin
    cnt_next   = slot_end ? '0 : slot_cnt + 1'b1;
    state_next = (cnt_next < BLANK_N) ? SCAN_BLANK : SCAN_DRIVE;
  end

  // Outputs
  always_comb begin
    slot_end     = (slot_cnt == LAST_CNT);
    blank_active = (state == SCAN_BLANK);
  end

endmodule

// File: rtl/display_scan_controller.sv
// Multiplexed 7-segment scanner with digit-enable mask, anti-ghosting blank
// time at every slot start and a frame-start pulse.
//
// Ports:
//   clk          system clock
//   reset        synchronous active-high reset
//   digit_en     per-digit enable, active-high
//   brightness   (BRIGHTNESS_EN only) PWM duty in 1/16 steps, 4'hF = fully on
//   an           active-low anode drives, registered, at most one bit low
//   seg_sel      index of the digit being scanned, registered
//   frame_start  one-cycle pulse when the scan wraps to a new frame
//
// Build option: define BRIGHTNESS_EN to add the brightness input and the
// free-running 4-bit PWM counter that gates the anode during SCAN_DRIVE.
module display_scan_controller
  import display_pkg::*;
#(
  parameter  int NUM_DIGITS   = 8,
  parameter  int TICK_DIV     = 100000,
  parameter  int BLANK_CYCLES = 16,
  localparam int SEL_W        = $clog2(NUM_DIGITS)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_DIGITS-1:0] digit_en,
`ifdef BRIGHTNESS_EN
  input  logic [3:0]            brightness,
`endif
  output logic [NUM_DIGITS-1:0] an,
  output logic [SEL_W-1:0]      seg_sel,
  output logic                  frame_start
);

  localparam logic [MAX_DIGITS-1:0] ALL_OFF_EXT = anode_all_off(NUM_DIGITS);
  localparam logic [NUM_DIGITS-1:0] ALL_OFF     = ALL_OFF_EXT[NUM_DIGITS-1:0];

  logic                  slot_end;
  logic                  blank_active;
  logic                  pwm_on;
  logic [MAX_DIGITS-1:0] mask_ext;
  next_idx_t             nxt;
  logic [NUM_DIGITS-1:0] an_next;

  scan_prescaler #(
    .TICK_DIV     (TICK_DIV),
    .BLANK_CYCLES (BLANK_CYCLES)
  ) u_prescaler (
    .clk          (clk),
    .reset        (reset),
    .slot_end     (slot_end),
    .blank_active (blank_active)
  );

`ifdef BRIGHTNESS_EN
  logic [3:0] pwm_cnt;

  always_ff @(posedge clk) begin
    if (reset) pwm_cnt <= '0;
    else       pwm_cnt <= pwm_cnt + 4'd1;
  end

  // 4'hF is treated as fully on rather than 15/16.
  assign pwm_on = (brightness == 4'hF) || (pwm_cnt < brightness);
`else
  assign pwm_on = 1'b1;
`endif

  always_comb begin
    mask_ext                 = '0;
    mask_ext[NUM_DIGITS-1:0] = digit_en;
  end

  assign nxt = next_enabled_idx(mask_ext, IDX_W'(seg_sel), NUM_DIGITS);

  // digit_en is used live so a disabled digit goes dark within one cycle,
  // even though seg_sel itself only moves at slot end.
  always_comb begin
    an_next = ALL_OFF;
    if (!blank_active && digit_en[seg_sel] && pwm_on) an_next[seg_sel] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      an          <= ALL_OFF;
      seg_sel     <= '0;
      frame_start <= 1'b0;
    end else begin
      an          <= an_next;
      frame_start <= 1'b0;
      if (slot_end) begin
        // With no digit enabled the index parks at 0 and no frame is signalled.
        seg_sel     <= nxt.found ? SEL_W'(nxt.idx) : '0;
        frame_start <= nxt.found && nxt.wrap;
      end
    end
  end

endmodule

// File: tb/tb_display_scan_controller.sv
module tb_display_scan_controller;

  localparam int N  = 8;
  localparam int TD = 10;
  localparam int BC = 2;
  localparam int W  = 12;

  // ---------------- clock / reset ----------------
  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [N-1:0] digit_en = '0;
  logic [N-1:0] an;
  logic [2:0]   seg_sel;
  logic         frame_start;
`ifdef BRIGHTNESS_EN
  logic [3:0]   brightness = 4'hF;
`endif

  always #5 clk = ~clk;

  display_scan_controller #(
    .NUM_DIGITS   (N),
    .TICK_DIV     (TD),
    .BLANK_CYCLES (BC)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .digit_en    (digit_en),
`ifdef BRIGHTNESS_EN
    .brightness  (brightness),
`endif
    .an          (an),
    .seg_sel     (seg_sel),
    .frame_start (frame_start)
  );

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  int tests_run = 0;
  int fail_cnt  = 0;
  int cyc       = 0;

  // reference model state (values visible after the most recent edge)
  int         m_cnt = 0;
  int         m_sel = 0;
  logic [7:0] m_an  = 8'hFF;
  logic       m_fs  = 1'b0;

  // per-phase statistics
  int         fs_count;
  int         fe_count;
  int         ff_count;
  logic [7:0] low_seen;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    assert (got === exp) else begin
      fail_cnt++;
      $error("FAIL %s (cycle %0d): observed %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  // Behavioural model of one clock edge, from the inputs held before it.
  task automatic model_edge();
    bit hit;
    int new_sel;
    hit     = 1'b0;
    new_sel = 0;
    if (reset) begin
      m_cnt = 0;
      m_sel = 0;
      m_an  = 8'hFF;
      m_fs  = 1'b0;
    end else begin
      m_an = 8'hFF;
      if (m_cnt >= BC && digit_en[m_sel]) m_an[m_sel] = 1'b0;
      m_fs = 1'b0;
      if (m_cnt == TD - 1) begin
        for (int k = 1; k <= N; k++) begin
          if (!hit && digit_en[(m_sel + k) % N]) begin
            hit     = 1'b1;
            new_sel = (m_sel + k) % N;
            m_fs    = (m_sel + k >= N);
          end
        end
        m_sel = hit ? new_sel : 0;
        m_cnt = 0;
      end else begin
        m_cnt++;
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic step();
    logic [W-1:0] e;
    @(posedge clk);
    model_edge();
    exp_q.push_back({m_an, 3'(m_sel), m_fs});
    cyc++;
    @(negedge clk);
    e = exp_q.pop_front();
    check("sb_an", 32'(an), 32'(e[11:4]));
    check("sb_seg_sel", 32'(seg_sel), 32'(e[3:1]));
    check("sb_frame_start", 32'(frame_start), 32'(e[0]));
    if (frame_start) fs_count++;
    if (an == 8'hFE) fe_count++;
    if (an == 8'hFF) ff_count++;
    low_seen = low_seen | ~an;
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  task automatic clear_stats();
    fs_count = 0;
    fe_count = 0;
    ff_count = 0;
    low_seen = '0;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    clear_stats();
    @(negedge clk);

    // reset state
    reset    = 1'b1;
    digit_en = '0;
    run(3);
    check("reset_an", 32'(an), 32'hFF);
    check("reset_seg_sel", 32'(seg_sel), 32'd0);

    // all digits enabled: two full frames
    reset    = 1'b0;
    digit_en = 8'hFF;
    clear_stats();
    run(160);
    check("full_frame_pulses", 32'(fs_count), 32'd2);
    check("full_digit0_low_cycles", 32'(fe_count), 32'd16);
    check("full_end_seg_sel", 32'(seg_sel), 32'd0);

    // sparse mask 1000_0101: eight frames of 0,2,7
    digit_en = 8'b1000_0101;
    clear_stats();
    run(240);
    check("sparse_frame_pulses", 32'(fs_count), 32'd8);
    check("sparse_lit_digits", 32'(low_seen), 32'h85);
    check("sparse_end_seg_sel", 32'(seg_sel), 32'd0);
    run(10);
    check("sparse_second_digit", 32'(seg_sel), 32'd2);

    // nothing enabled
    digit_en = 8'h00;
    clear_stats();
    run(30);
    check("none_an_off_cycles", 32'(ff_count), 32'd30);
    check("none_frame_pulses", 32'(fs_count), 32'd0);
    check("none_seg_sel", 32'(seg_sel), 32'd0);

    // clear the current digit mid-DRIVE
    reset = 1'b1;
    run(1);
    reset    = 1'b0;
    digit_en = 8'hFF;
    run(35);
    check("middrive_seg_sel", 32'(seg_sel), 32'd3);
    check("middrive_an_before", 32'(an), 32'hF7);
    digit_en = 8'hF7;
    run(1);
    check("middrive_an_after", 32'(an), 32'hFF);
    check("middrive_sel_held", 32'(seg_sel), 32'd3);
    run(4);
    check("middrive_next_sel", 32'(seg_sel), 32'd4);

    // reset in the middle of slot 5
    digit_en = 8'hFF;
    run(15);
    check("midreset_seg_sel_before", 32'(seg_sel), 32'd5);
    reset = 1'b1;
    run(1);
    check("midreset_an", 32'(an), 32'hFF);
    check("midreset_seg_sel", 32'(seg_sel), 32'd0);
    check("midreset_frame_start", 32'(frame_start), 32'd0);
    reset = 1'b0;
    run(9);
    check("resume_slot0_hold", 32'(seg_sel), 32'd0);
    run(1);
    check("resume_slot1", 32'(seg_sel), 32'd1);

    check("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, fail_cnt);
    $finish;
  end

endmodule
